ysyx_23060332_ifu: RTL

Instruction fetch unit for the single-issue RV32 core. Owns the PC, issues one instruction-memory read at a time over a valid/ready request plus response-valid interface, and presents the fetched word and its address to the decode stage under a valid/ready handshake. Applies branch/jump redirects reported by the execute stage when the current instruction retires, and supports an asynchronous-to-pipeline flush (trap/xret) from any state.

---
 rtl/ysyx_23060332_ifu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, keeps one memory read in flight and holds the fetched word for decode.
// Define YSYX_23060332_IFU_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        flush,
    input  logic [31:0] flush_pc
`ifdef YSYX_23060332_IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    // S_REQ: request offered to memory | S_WAIT: awaiting read data | S_HOLD: word offered to decode
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;

    wire         w_retire = (r_state == S_HOLD) && inst_ready;
    wire [31:0]  w_seq_pc = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst      <= INST_NOP;
            r_inst_addr <= RESET_PC;
        end else if (flush) begin
            r_pc <= flush_pc & ADDR_MASK;
            case (r_state)
                S_REQ: begin
                    // an accepted request still owes a response, which must be thrown away
                    if (req_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_REQ;
                    r_inst  <= INST_NOP;
                end
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (req_ready) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst      <= resp_data;
                            r_inst_addr <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        r_pc    <= jump_en ? (jump_addr & ADDR_MASK) : w_seq_pc;
                        r_inst  <= INST_NOP;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // rst gates the request so nothing is offered to memory while the core is held in reset
    assign req_valid   = (r_state == S_REQ) && !rst;
    assign req_addr    = r_pc;
    assign inst_valid  = (r_state == S_HOLD);
    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;

`ifdef YSYX_23060332_IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (w_retire && !flush) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (((r_state == S_REQ) && !req_ready) || ((r_state == S_WAIT) && !resp_valid))
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`else
    wire w_unused_retire = w_retire;
`endif

endmodule
